// File: rtl/aes_key_sched_ctrl_if.sv
// Bundle between the key-schedule sequencer, its host/cipher core and the
// single-round key-expansion unit. The slave side is the sequencer.
interface aes_key_sched_ctrl_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         ready;
  logic         ke_rst_n_o;
  logic [127:0] ke_key_o;
  logic [2:0]   ke_state_o;
  logic [3:0]   ke_round_o;
  logic [3:0]   ke_cnt_o;
  logic         ke_inv_en_o;
  logic [127:0] ke_round_key_i;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_ack;
  logic         rk_err;
  logic [127:0] rk_data;

  modport slave (
    input  start, key_in, ke_round_key_i, rk_req, rk_idx,
    output busy, ready, ke_rst_n_o, ke_key_o, ke_state_o, ke_round_o,
           ke_cnt_o, ke_inv_en_o, rk_ack, rk_err, rk_data
  );

  modport master (
    output start, key_in, ke_round_key_i, rk_req, rk_idx,
    input  busy, ready, ke_rst_n_o, ke_key_o, ke_state_o, ke_round_o,
           ke_cnt_o, ke_inv_en_o, rk_ack, rk_err, rk_data
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: steps a single-round expansion unit through
// rounds 1..10, stores the 11 round keys and serves random-access reads.
module aes_key_sched_ctrl #(
  parameter int         NR        = 10,
  parameter logic [2:0] ARK_CODE  = 3'd1,
  parameter logic [2:0] IDLE_CODE = 3'd0
) (
  input logic                clk,
  input logic                rst_n,
  aes_key_sched_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t       state, state_nx;
  logic         busy_q, ready_q, ke_rst_q;
  logic [127:0] key_q;
  logic [2:0]   kst_q;
  logic [3:0]   round_q, cnt_q;

  logic         busy_nx, ready_nx, ke_rst_nx;
  logic [2:0]   kst_nx;
  logic [3:0]   round_nx, cnt_nx;
  logic         key_ld, cap;

  logic [127:0] rk_buf [0:NR];

  logic         ack_p1, err_p1;
  logic [127:0] data_p1;
  logic         idx_ok, rd_hit;
  logic [3:0]   rd_idx;

  always_comb begin
    state_nx  = state;
    busy_nx   = busy_q;
    ready_nx  = ready_q;
    ke_rst_nx = 1'b1;
    kst_nx    = kst_q;
    round_nx  = round_q;
    cnt_nx    = cnt_q;
    key_ld    = 1'b0;
    cap       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nx  = S_LOAD;
          busy_nx   = 1'b1;
          ready_nx  = 1'b0;
          ke_rst_nx = 1'b0;
          key_ld    = 1'b1;
        end
      end
      S_LOAD: begin
        state_nx = S_RUN;
        round_nx = 4'd1;
        cnt_nx   = 4'd0;
        kst_nx   = ARK_CODE;
      end
      S_RUN: begin
        // cnt 6 is the capture slot: the unit holds its result while idle
        if (cnt_q == 4'd6) begin
          cap = 1'b1;
          if (round_q < 4'(NR)) begin
            round_nx = round_q + 4'd1;
            cnt_nx   = 4'd0;
            kst_nx   = ARK_CODE;
          end else begin
            state_nx = S_DONE;
            busy_nx  = 1'b0;
            ready_nx = 1'b1;
            kst_nx   = IDLE_CODE;
            round_nx = 4'd0;
            cnt_nx   = 4'd0;
          end
        end else begin
          cnt_nx = cnt_q + 4'd1;
          kst_nx = (cnt_q == 4'd5) ? IDLE_CODE : ARK_CODE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Read port evaluated against pre-edge ready, so a read racing a restart sees old keys
  assign idx_ok = (bus.rk_idx <= 4'(NR));
  assign rd_hit = bus.rk_req & ready_q & idx_ok;
  assign rd_idx = idx_ok ? bus.rk_idx : 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      ke_rst_q <= 1'b1;
      key_q    <= '0;
      kst_q    <= IDLE_CODE;
      round_q  <= 4'd0;
      cnt_q    <= 4'd0;
      ack_p1   <= 1'b0;
      err_p1   <= 1'b0;
      data_p1  <= '0;
    end else begin
      state    <= state_nx;
      busy_q   <= busy_nx;
      ready_q  <= ready_nx;
      ke_rst_q <= ke_rst_nx;
      kst_q    <= kst_nx;
      round_q  <= round_nx;
      cnt_q    <= cnt_nx;
      if (key_ld) key_q <= bus.key_in;
      ack_p1   <= bus.rk_req;
      err_p1   <= bus.rk_req & ~(ready_q & idx_ok);
      data_p1  <= rd_hit ? rk_buf[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (key_ld) rk_buf[0] <= bus.key_in;
    if (cap)    rk_buf[round_q] <= bus.ke_round_key_i;
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.ke_rst_n_o  = ke_rst_q;
  assign bus.ke_key_o    = key_q;
  assign bus.ke_state_o  = kst_q;
  assign bus.ke_round_o  = round_q;
  assign bus.ke_cnt_o    = cnt_q;
  assign bus.ke_inv_en_o = 1'b0;
  assign bus.rk_ack      = ack_p1;
  assign bus.rk_err      = err_p1;
  assign bus.rk_data     = data_p1;

endmodule
